// File: rtl/mem_stage_pkg.sv
// Shared FSM encoding and address-map defaults for the multicycle MEM stage.
package mem_stage_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned MEM_BASE_ADDR  = 1024;
   localparam int unsigned MEM_WORD_SHIFT = 2;
endpackage

// File: rtl/data_memory_sp.sv
// Single-port data array: synchronous write, combinational read.
module data_memory_sp
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_array [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_array[addr] <= wdata;
      end
   end

   assign rdata = mem_array[addr];
endmodule

// File: rtl/mem_stage_mc.sv
// Multicycle MEM stage: fixed-latency data memory access with pipeline freeze.
// Optional address range checking is enabled by defining MEM_STAGE_RANGE_CHECK_EN.
module mem_stage_mc
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned BASE_ADDR = MEM_BASE_ADDR,
   parameter int unsigned LATENCY   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic [DATA_W-1:0] ALU_result_in,
   input  logic [DATA_W-1:0] ST_val,
   output logic              mem_freeze,
   output logic [DATA_W-1:0] Mem_read_value,
   output logic              mem_done,
   output logic              mem_range_err
);
   localparam int unsigned AW = $clog2(DEPTH);
   // Counter only has to hold LATENCY-1.
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t            state_reg, state_next;
   logic [CW-1:0]     count_reg;
   logic [DATA_W-1:0] addr_reg, data_reg, read_value_reg;
   logic              store_reg;
   logic              request, accept, finish, in_range, mem_we;
   logic [DATA_W-1:0] offset, rdata;
   logic [AW-1:0]     word_index;

   assign request    = MEM_R_EN_in | MEM_W_EN_in;
   assign accept     = (state_reg == IDLE) && request;
   assign finish     = (state_reg == BUSY) && (count_reg == '0);
   assign offset     = addr_reg - DATA_W'(BASE_ADDR);
   assign word_index = offset[MEM_WORD_SHIFT +: AW];

`ifdef MEM_STAGE_RANGE_CHECK_EN
   // Addresses below BASE_ADDR wrap to a huge offset and fail this compare.
   assign in_range = (offset < DATA_W'(4 * DEPTH));
`else
   assign in_range = 1'b1;
`endif

   assign mem_we = finish && store_reg && in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (request) state_next = BUSY;
         BUSY:    if (count_reg == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_freeze = accept || (state_reg == BUSY);
      mem_done   = (state_reg == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg      <= '0;
         addr_reg       <= '0;
         data_reg       <= '0;
         store_reg      <= 1'b0;
         read_value_reg <= '0;
      end else begin
         if (accept) begin
            addr_reg  <= ALU_result_in;
            data_reg  <= ST_val;
            store_reg <= MEM_W_EN_in;
            count_reg <= CW'(LATENCY - 1);
         end else if ((state_reg == BUSY) && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
         end
         if (finish && !store_reg) begin
            read_value_reg <= in_range ? rdata : '0;
         end
      end
   end

`ifdef MEM_STAGE_RANGE_CHECK_EN
   logic range_err_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         range_err_reg <= 1'b0;
      end else begin
         range_err_reg <= finish && !in_range;
      end
   end

   assign mem_range_err = range_err_reg;
`else
   assign mem_range_err = 1'b0;
`endif

   assign Mem_read_value = read_value_reg;

   data_memory_sp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (word_index),
      .wdata (data_reg),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed self-checking bench for mem_stage_mc (DEPTH=256, LATENCY=3, BASE_ADDR=1024).
module tb_mem_stage_mc;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r, mem_w;
   logic [31:0] alu, st;
   logic        freeze, done, rerr;
   logic [31:0] rd_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_mc #(
      .DATA_W    (32),
      .DEPTH     (256),
      .BASE_ADDR (1024),
      .LATENCY   (LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .MEM_R_EN_in    (mem_r),
      .MEM_W_EN_in    (mem_w),
      .ALU_result_in  (alu),
      .ST_val         (st),
      .mem_freeze     (freeze),
      .Mem_read_value (rd_val),
      .mem_done       (done),
      .mem_range_err  (rerr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One full access: request held from cycle 0 through the DONE cycle.
   task automatic access(input string tag, input logic r, input logic w,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic chk_rd, input logic [31:0] exp_rd,
                         input logic exp_err);
      @(posedge clk);
      #1;
      mem_r = r;
      mem_w = w;
      alu   = addr;
      st    = data;
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge clk);
         check({tag, " freeze"}, {31'b0, freeze}, {31'b0, (c <= LAT)});
         check({tag, " done"}, {31'b0, done}, {31'b0, (c == LAT + 1)});
         check({tag, " range_err"}, {31'b0, rerr}, {31'b0, (c == LAT + 1) && exp_err});
      end
      if (chk_rd) check({tag, " read_value"}, rd_val, exp_rd);
      $display("txn %s r=%0b w=%0b addr=%0d st=%08h read_value=%08h err=%0b",
               tag, r, w, addr, data, rd_val, exp_err);
      mem_r = 1'b0;
      mem_w = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      mem_r = 1'b0;
      mem_w = 1'b0;
      alu   = 32'd0;
      st    = 32'd0;
      repeat (2) @(negedge clk);
      check("reset freeze", {31'b0, freeze}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset read_value", rd_val, 32'd0);
      check("reset range_err", {31'b0, rerr}, 32'd0);
      rst = 1'b0;

      // Store then load
      access("st_1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
      access("ld_1028", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

      // Idle period, then load word 2 (initialised here)
      access("init_1032", 1'b0, 1'b1, 32'd1032, 32'h13572468, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle freeze", {31'b0, freeze}, 32'd0);
         check("idle done", {31'b0, done}, 32'd0);
      end
      access("ld_1032", 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 32'h13572468, 1'b0);

      // Simultaneous read and write behaves as a store
      access("st_1044", 1'b0, 1'b1, 32'd1044, 32'h11111111, 1'b0, 32'd0, 1'b0);
      access("ld_1044", 1'b1, 1'b0, 32'd1044, 32'h0, 1'b1, 32'h11111111, 1'b0);
      access("rw_1036", 1'b1, 1'b1, 32'd1036, 32'h22222222, 1'b1, 32'h11111111, 1'b0);
      @(negedge clk);
      check("rw hold read_value", rd_val, 32'h11111111);
      access("ld_1036", 1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, 32'h22222222, 1'b0);

      // Reset in the second BUSY cycle discards the store
      access("st_1040", 1'b0, 1'b1, 32'd1040, 32'h01234567, 1'b0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      mem_w = 1'b1;
      alu   = 32'd1040;
      st    = 32'hCAFEF00D;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b1;
      mem_w = 1'b0;
      #1;
      check("rst_busy freeze", {31'b0, freeze}, 32'd0);
      check("rst_busy read_value", rd_val, 32'd0);
      check("rst_busy done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst freeze", {31'b0, freeze}, 32'd0);
      check("post_rst done", {31'b0, done}, 32'd0);
      $display("txn rst_mid_busy st=cafef00d addr=1040 read_value=%08h", rd_val);
      access("ld_1040", 1'b1, 1'b0, 32'd1040, 32'h0, 1'b1, 32'h01234567, 1'b0);

`ifdef MEM_STAGE_RANGE_CHECK_EN
      // 1020 would alias word 255 (byte 2044) if it were not blocked
      access("st_2044", 1'b0, 1'b1, 32'd2044, 32'h77777777, 1'b0, 32'd0, 1'b0);
      access("st_1020", 1'b0, 1'b1, 32'd1020, 32'h99999999, 1'b0, 32'd0, 1'b1);
      access("ld_2044", 1'b1, 1'b0, 32'd2044, 32'h0, 1'b1, 32'h77777777, 1'b0);
      access("ld_2048", 1'b1, 1'b0, 32'd2048, 32'h0, 1'b1, 32'h00000000, 1'b1);
`else
      // 2048 wraps onto word 0
      access("st_2048", 1'b0, 1'b1, 32'd2048, 32'hA5A5A5A5, 1'b0, 32'd0, 1'b0);
      access("ld_1024", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0);
`endif

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage_mc.md
# mem_stage_mc

Parametrised multicycle memory stage for the MIPS pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It maps the ALU byte address into a word-indexed data memory, models a configurable access latency with an internal FSM, and freezes the upstream pipeline via `mem_freeze` until the access completes. It extends the single-cycle MEM stage with variable latency, a completion pulse, a held read register and optional address range checking.

## Interface
Parameters:
- `DATA_W`, 32: data and address width.
- `DEPTH`, 256: number of data words in memory; power of two, at least 2.
- `BASE_ADDR`, 1024: byte address of word 0.
- `LATENCY`, 3: wait cycles per access; at least 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `MEM_R_EN_in`, input, 1: load request.
- `MEM_W_EN_in`, input, 1: store request.
- `ALU_result_in`, input, DATA_W: byte address.
- `ST_val`, input, DATA_W: store data.
- `mem_freeze`, output, 1: stall request to IF/ID/EX and the pipeline registers.
- `Mem_read_value`, output, DATA_W: registered load result.
- `mem_done`, output, 1: one-cycle access-complete pulse.
- `mem_range_err`, output, 1: one-cycle out-of-range pulse. Tied to 0 when the range-check feature is compiled out.

## Operation
- Word index = `(ALU_result_in - BASE_ADDR) >> 2`, computed modulo 2^DATA_W. Bits [1:0] are ignored.
- A request is present when `MEM_R_EN_in | MEM_W_EN_in` is high. If both are high, the access is a store and `Mem_read_value` is unchanged.
- FSM states are IDLE, BUSY and DONE.
  - IDLE with a request: latch the address, data and op. Load the counter with LATENCY-1 and go to BUSY.
  - BUSY with counter != 0: decrement the counter.
  - BUSY with counter == 0: at this edge, write the array (store) or capture the array word into `Mem_read_value` (load). Go to DONE.
  - DONE: ignore all inputs. Go to IDLE. The instruction still present on the inputs is the completed one.
- `mem_freeze` = (IDLE && request) || BUSY. It is combinational from the request inputs in IDLE.
- `mem_done` = (state == DONE).
- `Mem_read_value` holds the last completed load until the next load completes.
- Reset (async, at any time, including mid-BUSY):
  - The state goes to IDLE, the counter to 0, and `Mem_read_value`, `mem_done` and `mem_range_err` go to 0.
  - `mem_freeze` follows the request inputs as in IDLE.
  - Any pending store is discarded.
  - Array contents are not reset.

## Timing
- A request first seen in cycle 0 gives `mem_freeze` high in cycles 0 through LATENCY.
- In cycle LATENCY+1: DONE state, `mem_freeze` low, `mem_done` high, load data valid.
- The stage occupancy is therefore LATENCY+2 cycles.
- A new request is accepted in the cycle after DONE.
- Store data becomes visible to a load that starts in any cycle after DONE.
- With no request, `mem_freeze` stays 0 and the FSM stays in IDLE.

## Configuration
- `MEM_STAGE_RANGE_CHECK_EN` defined:
  - An access is in range when `BASE_ADDR <= ALU_result_in < BASE_ADDR + 4*DEPTH`. An out-of-range request still runs the full FSM with identical timing.
  - At completion the store is suppressed, or the load returns 0.
  - `mem_range_err` pulses in the DONE cycle.
- Not defined:
  - The word index is taken modulo DEPTH, so accesses wrap.
  - `mem_range_err` is constant 0.

## Structure
- Package `mem_stage_pkg`:
  - FSM state encoding (IDLE=0, BUSY=1, DONE=2).
  - Default constants `MEM_BASE_ADDR` (1024) and `MEM_WORD_SHIFT` (2).
- Sub-module `data_memory_sp`:
  - Single-port array of DEPTH by DATA_W words with a synchronous write and a combinational read.
  - Instantiated once.
  - All FSM, counter and range logic stays in `mem_stage_mc`.

## Test plan
All scenarios use DEPTH=256, LATENCY=3 and BASE_ADDR=1024.
- **Store then load.** Store 0xDEADBEEF to address 1028, then load from 1028.
  - Each access: `mem_freeze` high for 4 cycles, then `mem_done` high for 1 cycle.
  - `Mem_read_value` = 0xDEADBEEF.
- **Idle bench.** Both enables at 0 for 20 cycles, then a load from 1032.
  - `mem_freeze` and `mem_done` stay 0 throughout the idle period.
  - Load returns the initialised contents of word 2.
- **Simultaneous R and W.** `Mem_read_value` = 0x11111111; assert load and store to 1036 with `ST_val` 0x22222222 in the same cycle.
  - A store is performed.
  - `Mem_read_value` stays 0x11111111.
  - A later load from 1036 returns 0x22222222.
- **Reset mid-BUSY.** Store 0xCAFEF00D to 1040; assert `rst` in the second BUSY cycle.
  - Immediately: `mem_freeze` low (enables dropped), `Mem_read_value` = 0.
  - A later load from 1040 returns the old contents.
- **Range check, macro defined.**
  - Store to 1020: `mem_range_err` pulses in DONE and memory is unchanged.
  - Load from 2048: returns 0 and `mem_range_err` pulses.
- **Range check, macro undefined.** Store 0xA5A5A5A5 to 2048, then load from 1024.
  - Load returns 0xA5A5A5A5 (wrap-around).
  - `mem_range_err` stays 0.
